// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DEF_REG_ADDR_WIDTH : default register index width
//   DEF_DATA_WIDTH     : default register data width
//   arb_state_t        : arbiter FSM state (CLEAR, RUN)
package regfile_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH     = 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared port.
// Ports:
//   req_valid [NUM_REQ]     : pending request per requester
//   rr_ptr    [IDX_W]       : index searched first (highest priority this cycle)
//   grant     [NUM_REQ]     : one-hot grant (all zero when nothing is valid)
//   grant_idx [IDX_W]       : index of the granted requester
//   any_grant                : some requester was granted
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_grant
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // One extra bit so rr_ptr + k can be wrapped without overflow.
    logic [IDX_W:0]   idx_ext;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx_ext   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (idx_ext >= (IDX_W + 1)'(NUM_REQ)) begin
                idx_ext = idx_ext - (IDX_W + 1)'(NUM_REQ);
            end
            idx = idx_ext[IDX_W-1:0];
            if (!any_grant && req_valid[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register_file write port between NUM_REQ writeback
// requesters using round-robin arbitration and a valid/ready handshake.
// An accepted request appears on write_en/regw/dataw/grant_id one cycle later.
//
// Optional feature: define REGFILE_ARB_CLEAR_EN to walk every register to
// zero after each reset before any grant is issued (busy high meanwhile).
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester write pending
//   req_addr   : per-requester destination register
//   req_data   : per-requester write data
//   req_ready  : one-hot grant, combinational (transfer = valid & ready)
//   write_en   : register_file write enable (registered)
//   regw       : register_file write index (registered)
//   dataw      : register_file write data (registered)
//   grant_id   : requester behind the current write (registered)
//   busy       : clear sequence running, no grants
//
// state | meaning
// CLEAR | issuing zero-writes to every register, requesters held off
// RUN   | round-robin arbitration of writeback requests
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic                                     write_en,
    output logic [REG_ADDR_WIDTH-1:0]                regw,
    output logic [DATA_WIDTH-1:0]                    dataw,
    output logic [$clog2(NUM_REQ)-1:0]               grant_id,
    output logic                                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t                state;
    logic [IDX_W-1:0]          rr_ptr;
    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      any_grant;
    logic                      run_en;
    logic                      clr_done;
    logic [REG_ADDR_WIDTH-1:0] clr_addr;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Reset gates the grant directly so no transfer can be taken while
    // rst is high, even in builds where the reset state is RUN.
    assign run_en    = (state == RUN) && !rst;
    assign req_ready = run_en ? grant : '0;

`ifdef REGFILE_ARB_CLEAR_EN
    localparam arb_state_t RESET_STATE = CLEAR;

    // The extra MSB marks that all NUM_REGS zero-writes have been issued.
    logic [REG_ADDR_WIDTH:0] clr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR && !clr_done) begin
            clr_cnt <= clr_cnt + (REG_ADDR_WIDTH + 1)'(1);
        end
    end

    assign clr_done = clr_cnt[REG_ADDR_WIDTH];
    assign clr_addr = clr_cnt[REG_ADDR_WIDTH-1:0];
    assign busy     = (state == CLEAR);
`else
    localparam arb_state_t RESET_STATE = RUN;

    assign clr_done = 1'b1;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            rr_ptr   <= '0;
            write_en <= 1'b0;
            regw     <= '0;
            dataw    <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_done) begin
                        write_en <= 1'b0;
                        state    <= RUN;
                    end else begin
                        write_en <= 1'b1;
                        regw     <= clr_addr;
                        dataw    <= '0;
                    end
                end
                default: begin
                    // regw/dataw keep their last value on idle cycles.
                    write_en <= any_grant;
                    if (any_grant) begin
                        regw     <= req_addr[grant_idx];
                        dataw    <= req_data[grant_idx];
                        grant_id <= grant_idx;
                        rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                       : grant_idx + IDX_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0][3:0] req_addr;
    logic [1:0][7:0] req_data;
    logic [1:0]      req_ready;
    logic            write_en;
    logic [3:0]      regw;
    logic [7:0]      dataw;
    logic [0:0]      grant_id;
    logic            busy;

    int checks   = 0;
    int failures = 0;

`ifdef REGFILE_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    // register_file stand-in: captures on the rising edge when write_en is high.
    logic [7:0] rf [16] = '{default: 8'h5A};

    always @(posedge clk) begin
        if (write_en) rf[regw] <= dataw;
    end

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ        (2),
        .REG_ADDR_WIDTH (4),
        .DATA_WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .write_en  (write_en),
        .regw      (regw),
        .dataw     (dataw),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_addr  = '0;
        req_data  = '0;
        step();
        step();
        #1;
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", write_en); end
        checks++; if (regw !== 4'd0) begin failures++; $display("FAIL reset_regw got=%0d exp=0", regw); end
        checks++; if (dataw !== 8'h00) begin failures++; $display("FAIL reset_dataw got=%h exp=00", dataw); end
        checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if (busy !== CLR_EN) begin failures++; $display("FAIL reset_busy got=%0b exp=%0b", busy, CLR_EN); end
    endtask

`ifdef REGFILE_ARB_CLEAR_EN
    task automatic test_clear();
        step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_c0_busy got=%0b exp=1", busy); end
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL clear_c0_we got=%0b exp=0", write_en); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL clear_c0_ready got=%b exp=00", req_ready); end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL clear_we k=%0d got=%0b exp=1", k, write_en); end
            checks++; if (regw !== 4'(k)) begin failures++; $display("FAIL clear_regw got=%0d exp=%0d", regw, k); end
            checks++; if (dataw !== 8'h00) begin failures++; $display("FAIL clear_dataw k=%0d got=%h exp=00", k, dataw); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy k=%0d got=%0b exp=1", k, busy); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL clear_ready k=%0d got=%b exp=00", k, req_ready); end
        end
        req_valid = 2'b00;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_end_busy got=%0b exp=0", busy); end
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL clear_end_we got=%0b exp=0", write_en); end
        for (int r = 0; r < 16; r++) begin
            checks++; if (rf[r] !== 8'h00) begin failures++; $display("FAIL clear_rf r=%0d got=%h exp=00", r, rf[r]); end
        end
    endtask
`else
    task automatic test_no_clear();
        step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noclr_busy got=%0b exp=0", busy); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL noclr_ready got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL noclr_we got=%0b exp=0", write_en); end
    endtask
`endif

    task automatic test_single();
        req_valid   = 2'b01;
        req_addr[0] = 4'd1;
        req_data[0] = 8'hFF;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b00;
        checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL single_we got=%0b exp=1", write_en); end
        checks++; if (regw !== 4'd1) begin failures++; $display("FAIL single_regw got=%0d exp=1", regw); end
        checks++; if (dataw !== 8'hFF) begin failures++; $display("FAIL single_dataw got=%h exp=ff", dataw); end
        checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL single_ready_off got=%b exp=00", req_ready); end
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL single_we_off got=%0b exp=0", write_en); end
        checks++; if (rf[1] !== 8'hFF) begin failures++; $display("FAIL single_rf1 got=%h exp=ff", rf[1]); end
    endtask

    // Pointer sits at 1 after the previous grant of requester 0.
    task automatic test_rr_order();
        req_valid   = 2'b10;
        req_addr[1] = 4'd4;
        req_data[1] = 8'h44;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_ready_a got=%b exp=10", req_ready); end
        step();
        checks++; if (regw !== 4'd4 || dataw !== 8'h44 || grant_id !== 1'b1 || write_en !== 1'b1)
            begin failures++; $display("FAIL rr_out_a got=%0b/%0d/%h/%0d exp=1/4/44/1", write_en, regw, dataw, grant_id); end
        req_valid   = 2'b11;
        req_addr[0] = 4'd5;
        req_data[0] = 8'h55;
        req_addr[1] = 4'd6;
        req_data[1] = 8'h66;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_ready_b got=%b exp=01", req_ready); end
        step();
        checks++; if (regw !== 4'd5 || dataw !== 8'h55 || grant_id !== 1'b0 || write_en !== 1'b1)
            begin failures++; $display("FAIL rr_out_b got=%0b/%0d/%h/%0d exp=1/5/55/0", write_en, regw, dataw, grant_id); end
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_ready_c got=%b exp=10", req_ready); end
        step();
        checks++; if (regw !== 4'd6 || dataw !== 8'h66 || grant_id !== 1'b1 || write_en !== 1'b1)
            begin failures++; $display("FAIL rr_out_c got=%0b/%0d/%h/%0d exp=1/6/66/1", write_en, regw, dataw, grant_id); end
        req_valid = 2'b00;
        step();
        checks++; if (rf[4] !== 8'h44 || rf[5] !== 8'h55 || rf[6] !== 8'h66)
            begin failures++; $display("FAIL rr_rf got=%h/%h/%h exp=44/55/66", rf[4], rf[5], rf[6]); end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL idle_ready c=%0d got=%b exp=00", c, req_ready); end
            step();
            checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL idle_we c=%0d got=%0b exp=0", c, write_en); end
            checks++; if (regw !== 4'd6 || dataw !== 8'h66)
                begin failures++; $display("FAIL idle_hold c=%0d got=%0d/%h exp=6/66", c, regw, dataw); end
        end
        checks++; if (rf[1] !== 8'hFF || rf[6] !== 8'h66)
            begin failures++; $display("FAIL idle_rf got=%h/%h exp=ff/66", rf[1], rf[6]); end
    endtask

    // Pointer is back at 0; both requesters keep re-requesting the same write.
    task automatic test_back_to_back();
        req_valid   = 2'b11;
        req_addr[0] = 4'd2;
        req_data[0] = 8'hAB;
        req_addr[1] = 4'd3;
        req_data[1] = 8'hCD;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                begin failures++; $display("FAIL b2b_ready i=%0d got=%b", i, req_ready); end
            step();
            checks++; if (write_en !== 1'b1) begin failures++; $display("FAIL b2b_we i=%0d got=%0b exp=1", i, write_en); end
            checks++; if (grant_id !== 1'(i % 2)) begin failures++; $display("FAIL b2b_gid i=%0d got=%0d exp=%0d", i, grant_id, i % 2); end
            checks++; if (regw !== ((i % 2 == 0) ? 4'd2 : 4'd3) || dataw !== ((i % 2 == 0) ? 8'hAB : 8'hCD))
                begin failures++; $display("FAIL b2b_data i=%0d got=%0d/%h", i, regw, dataw); end
        end
        req_valid = 2'b00;
        step();
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL b2b_we_off got=%0b exp=0", write_en); end
        checks++; if (rf[2] !== 8'hAB || rf[3] !== 8'hCD)
            begin failures++; $display("FAIL b2b_rf got=%h/%h exp=ab/cd", rf[2], rf[3]); end
    endtask

    task automatic test_same_reg();
        req_valid   = 2'b11;
        req_addr[0] = 4'd7;
        req_data[0] = 8'h11;
        req_addr[1] = 4'd7;
        req_data[1] = 8'h22;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL same_ready_a got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b10;
        checks++; if (dataw !== 8'h11 || regw !== 4'd7) begin failures++; $display("FAIL same_out_a got=%0d/%h exp=7/11", regw, dataw); end
        step();
        req_valid = 2'b00;
        checks++; if (dataw !== 8'h22 || grant_id !== 1'b1) begin failures++; $display("FAIL same_out_b got=%h/%0d exp=22/1", dataw, grant_id); end
        step();
        checks++; if (rf[7] !== 8'h22) begin failures++; $display("FAIL same_rf7 got=%h exp=22", rf[7]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rf8_before;
        rf8_before = CLR_EN ? 8'h00 : 8'h5A;
        req_valid   = 2'b01;
        req_addr[0] = 4'd8;
        req_data[0] = 8'h99;
        step();
        req_valid = 2'b00;
        checks++; if (write_en !== 1'b1 || regw !== 4'd8) begin failures++; $display("FAIL mid_pending got=%0b/%0d exp=1/8", write_en, regw); end
        req_valid = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0 || regw !== 4'd0 || dataw !== 8'h00 || grant_id !== 1'b0)
            begin failures++; $display("FAIL mid_async got=%0b/%0d/%h/%0d exp=0/0/00/0", write_en, regw, dataw, grant_id); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_ready got=%b exp=00", req_ready); end
        checks++; if (busy !== CLR_EN) begin failures++; $display("FAIL mid_busy got=%0b exp=%0b", busy, CLR_EN); end
        req_valid = 2'b00;
        step();
        checks++; if (rf[8] !== rf8_before) begin failures++; $display("FAIL mid_dropped got=%h exp=%h", rf[8], rf8_before); end
`ifdef REGFILE_ARB_CLEAR_EN
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        checks++; if (regw !== 4'd5 || write_en !== 1'b1) begin failures++; $display("FAIL mid_clr5 got=%0b/%0d exp=1/5", write_en, regw); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mid_clr_async got=%0b/%0b exp=0/1", write_en, busy); end
        step();
        rst = 1'b0;
        step();
        checks++; if (regw !== 4'd0 || write_en !== 1'b1) begin failures++; $display("FAIL mid_restart0 got=%0b/%0d exp=1/0", write_en, regw); end
        step();
        checks++; if (regw !== 4'd1 || busy !== 1'b1) begin failures++; $display("FAIL mid_restart1 got=%0d/%0b exp=1/1", regw, busy); end
`else
        rst = 1'b0;
        step();
        checks++; if (write_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_run got=%0b/%0b exp=0/0", write_en, busy); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef REGFILE_ARB_CLEAR_EN
        test_clear();
`else
        test_no_clear();
`endif
        test_single();
        test_rr_order();
        test_idle();
        test_back_to_back();
        test_same_reg();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
